// File: rtl/booth_issue_ctrl.sv
// booth_issue_ctrl: issue/retire sequencer wrapped around the 12x8 booth_encode
// multiplier. Latches an operand pair, pulses start, follows the busy
// handshake with a timeout watchdog, and holds the product until it is taken.
module booth_issue_ctrl #(
    parameter int M_BITS  = 12,
    parameter int N_BITS  = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [M_BITS-1:0]        in_mpd,
    input  logic [N_BITS-1:0]        in_mpr,
    output logic                     in_ready,
    output logic [M_BITS-1:0]        mpd,
    output logic [N_BITS-1:0]        mpr,
    output logic                     start,
    input  logic                     busy,
    input  logic [M_BITS+N_BITS-1:0] answer,
    output logic                     out_valid,
    output logic [M_BITS+N_BITS-1:0] out_data,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_latency,
    output logic                     err
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_HI,
        WAIT_LO,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LAT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  lat_cnt;
    logic [CNT_W-1:0]  lat_inc;

    // Saturating next value of the latency counter; it includes the current
    // wait cycle, so a capture reports cycles from start to busy fall.
    always_comb begin
        lat_inc = (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + 1'b1;
    end

    // Sequencer FSM with all interface outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            mpd         <= '0;
            mpr         <= '0;
            start       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_latency <= '0;
            err         <= 1'b0;
            wait_cnt    <= '0;
            lat_cnt     <= '0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mpd      <= in_mpd;
                        mpr      <= in_mpr;
                        start    <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    lat_cnt  <= '0;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    lat_cnt <= lat_inc;
                    if (busy) begin
                        wait_cnt <= '0;
                        state    <= WAIT_LO;
                    end else if (wait_cnt == TO_LAST) begin
                        // Multiplier never raised busy: deliver whatever it drives.
                        err         <= 1'b1;
                        out_data    <= answer;
                        out_latency <= lat_inc;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    lat_cnt <= lat_inc;
                    if (!busy || wait_cnt == TO_LAST) begin
                        if (busy) begin
                            err <= 1'b1;
                        end
                        out_data    <= answer;
                        out_latency <= lat_inc;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Directed bench for booth_issue_ctrl with a behavioural multiplier model and
// a result scoreboard filled at operand issue and drained at result handshake.
module tb_booth_issue_ctrl;

    localparam int M = 12;
    localparam int N = 8;
    localparam int W = M + N;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [M-1:0]   in_mpd;
    logic [N-1:0]   in_mpr;
    logic           in_ready;
    logic [M-1:0]   mpd;
    logic [N-1:0]   mpr;
    logic           start;
    logic           busy;
    logic [W-1:0]   answer;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [6:0]     out_latency;
    logic           err;

    typedef struct {
        logic [W-1:0] data;
        int           lat;   // -1: latency not checked
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_results = 0;
    int   start_cnt = 0;
    int   hi_len = 0;
    int   bcnt;

    always #5 clk = ~clk;

    booth_issue_ctrl #(
        .M_BITS (12),
        .N_BITS (8),
        .TIMEOUT(64),
        .CNT_W  (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_mpd     (in_mpd),
        .in_mpr     (in_mpr),
        .in_ready   (in_ready),
        .mpd        (mpd),
        .mpr        (mpr),
        .start      (start),
        .busy       (busy),
        .answer     (answer),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_latency(out_latency),
        .err        (err)
    );

    // Multiplier model: busy high for hi_len cycles beginning the cycle after start.
    always @(posedge clk or posedge reset) begin
        if (reset) bcnt <= 0;
        else if (start) bcnt <= hi_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign busy = (bcnt != 0);

    always @(posedge clk) begin
        if (start === 1'b1) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard drain: a handshake is pending whenever valid & ready are both high here.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", 32'(out_data), 32'(e.data));
                chk("res_err", 32'(err), 32'(e.err));
                if (e.lat >= 0) chk("res_latency", 32'(out_latency), 32'(e.lat));
            end
            n_results++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [M-1:0] a, input logic [N-1:0] b,
                        input logic [W-1:0] ans, input int hl, input int lat, input logic e);
        int k;
        exp_t x;
        k = 0;
        while (in_ready !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) chk("in_ready_timeout", 0, 1);
        answer = ans;
        hi_len = hl;
        in_mpd = a;
        in_mpr = b;
        in_valid = 1'b1;
        x.data = ans;
        x.lat = lat;
        x.err = e;
        sb.push_back(x);
        tick();
        in_valid = 1'b0;
        chk("mpd_reg", 32'(mpd), 32'(a));
        chk("mpr_reg", 32'(mpr), 32'(b));
        chk("start_pulse", 32'(start), 1);
        chk("in_ready_busy", 32'(in_ready), 0);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        if (cyc >= 300) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_clear", 32'(out_valid), 0);
        chk("idle_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s0;
        int base;
        int k;

        reset = 1'b1;
        in_valid = 1'b0;
        in_mpd = '0;
        in_mpr = '0;
        out_ready = 1'b0;
        answer = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_start", 32'(start), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mpd", 32'(mpd), 0);
        chk("rst_out_latency", 32'(out_latency), 0);
        reset = 1'b0;
        tick();

        // Operand load: busy for 3 cycles -> latency 4
        s0 = start_cnt;
        send(12'hF00, 8'hF0, 20'h01000, 3, 4, 1'b0);
        wait_valid(c);
        chk("load_cycles", c, 5);
        chk("load_starts", start_cnt - s0, 1);
        chk("load_data", 32'(out_data), 32'h01000);
        release_result();

        // Held result under backpressure
        send(12'h7FF, 8'h80, 20'hC0080, 5, 6, 1'b0);
        wait_valid(c);
        chk("hold_cycles", c, 7);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_data", 32'(out_data), 32'hC0080);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_latency", 32'(out_latency), 6);
        end
        release_result();

        // Back-to-back with consumer always ready
        out_ready = 1'b1;
        base = n_results;
        s0 = start_cnt;
        send(12'h123, 8'h45, 20'hABCDE, 2, 3, 1'b0);
        send(12'h800, 8'h7F, 20'h0F0F0, 1, 2, 1'b0);
        chk("b2b_first_taken", n_results - base, 1);
        k = 0;
        while (n_results - base < 2 && k < 300) begin
            tick();
            k++;
        end
        chk("b2b_results", n_results - base, 2);
        chk("b2b_starts", start_cnt - s0, 2);
        out_ready = 1'b0;
        tick();

        // Stuck busy: timeout in WAIT_LO after 64 cycles
        send(12'h0AA, 8'h55, 20'h12345, 100000, -1, 1'b1);
        wait_valid(c);
        chk("stuck_cycles", c, 66);
        chk("stuck_err", 32'(err), 1);
        release_result();

        // Busy never rises: timeout in WAIT_HI, result still delivered
        send(12'hFFF, 8'hFF, 20'h00001, 0, -1, 1'b1);
        wait_valid(c);
        chk("nobusy_cycles", c, 65);
        chk("nobusy_err", 32'(err), 1);
        release_result();

        // Reset during WAIT_LO abandons the operation and clears err
        send(12'h456, 8'h12, 20'h55555, 50, -1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        chk("midrst_start", 32'(start), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_mpd", 32'(mpd), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_valid_after", 32'(out_valid), 0);

        // Normal transaction after reset
        send(12'hF00, 8'h7F, 20'hF8100, 4, 5, 1'b0);
        wait_valid(c);
        chk("post_rst_cycles", c, 6);
        release_result();

        chk("sb_empty", sb.size(), 0);
        chk("total_results", n_results, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
